// File: rtl/key_schedule_engine_pkg.sv
// Shared AES key-schedule definitions: word/key types, S-box and round-constant
// lookups, and the key-size-derived schedule dimensions.
package key_schedule_engine_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  key_word_t;
  typedef logic [127:0] round_key_t;

  typedef enum logic [1:0] {
    WORD_PLAIN = 2'd0,
    WORD_ROT   = 2'd1,
    WORD_SUB   = 2'd2
  } word_class_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic int nk_of(input int key_bits);
    return key_bits / 32;
  endfunction

  function automatic int nr_of(input int key_bits);
    return nk_of(key_bits) + 6;
  endfunction

  function automatic int nw_of(input int key_bits);
    return 4 * (nr_of(key_bits) + 1);
  endfunction

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic byte_t sbox(input byte_t b);
    return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic key_word_t sub_word(input key_word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic byte_t rcon(input logic [3:0] idx);
    byte_t r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_schedule_engine_word.sv
// Combinational single-word key-expansion step: RotWord/SubWord/RCON mixing
// of the previous word, folded into the word NK positions back.
module key_schedule_engine_word
  import key_schedule_engine_pkg::*;
(
  input  key_word_t   prev_word,
  input  key_word_t   word_nk_back,
  input  word_class_t word_class,
  input  byte_t       rcon_byte,
  output key_word_t   new_word
);

  key_word_t rot_s;
  key_word_t temp_s;

  // Select the transform applied to the previous word for this position.
  always_comb begin
    rot_s  = {prev_word[23:0], prev_word[31:24]};
    temp_s = prev_word;
    case (word_class)
      WORD_ROT:   temp_s = sub_word(rot_s) ^ {rcon_byte, 24'h000000};
      WORD_SUB:   temp_s = sub_word(prev_word);
      WORD_PLAIN: temp_s = prev_word;
      default:    temp_s = prev_word;
    endcase
  end

  assign new_word = word_nk_back ^ temp_s;

endmodule

// File: rtl/key_schedule_engine.sv
// Sequential AES key schedule: expands a 128/192/256-bit key one word per cycle
// into a flat word buffer and serves 4-word round keys through a registered port.
module key_schedule_engine
  import key_schedule_engine_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                keyValid,
  output logic                keyReady,
  input  logic [KEY_BITS-1:0] keyIn,
  input  logic [3:0]          rkIndex,
  output logic [127:0]        rkData,
  output logic                rkReady,
  output logic                busy
);

  localparam int NK = nk_of(KEY_BITS);
  localparam int NR = nr_of(KEY_BITS);
  localparam int NW = nw_of(KEY_BITS);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("key_schedule_engine: KEY_BITS must be 128, 192 or 256");
  end

  state_t      state_r;
  state_t      next_state_s;
  logic        key_ready_r;
  logic        rk_ready_r;
  logic        busy_r;
  logic [5:0]  cnt_r;
  logic [2:0]  phase_r;
  logic [3:0]  rc_r;
  key_word_t   win_r [NK];
  key_word_t   wbuf_r [NW];
  round_key_t  rk_data_r;

  logic        accept_s;
  logic        last_word_s;
  word_class_t word_class_s;
  key_word_t   new_word_s;
  logic [3:0]  rd_idx_s;
  logic [5:0]  rd_base_s;

  assign accept_s    = keyValid && key_ready_r;
  assign last_word_s = (cnt_r == 6'(NW - 1));

  // Classify the word being produced from its position within the NK-word period.
  always_comb begin
    word_class_s = WORD_PLAIN;
    if (phase_r == 3'd0) begin
      word_class_s = WORD_ROT;
    end else if (NK == 8 && phase_r == 3'd4) begin
      word_class_s = WORD_SUB;
    end else begin
      word_class_s = WORD_PLAIN;
    end
  end

  key_schedule_engine_word u_word (
    .prev_word    (win_r[NK-1]),
    .word_nk_back (win_r[0]),
    .word_class   (word_class_s),
    .rcon_byte    (rcon(rc_r)),
    .new_word     (new_word_s)
  );

  // Next-state logic for the IDLE/EXPAND/DONE controller.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) next_state_s = ST_EXPAND;
        else          next_state_s = ST_IDLE;
      end
      ST_EXPAND: begin
        if (last_word_s) next_state_s = ST_DONE;
        else             next_state_s = ST_EXPAND;
      end
      ST_DONE: begin
        if (accept_s) next_state_s = ST_EXPAND;
        else          next_state_s = ST_DONE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Controller state, status flags, word counter and the NK-word sliding window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      key_ready_r <= 1'b1;
      rk_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      cnt_r       <= 6'd0;
      phase_r     <= 3'd0;
      rc_r        <= 4'd0;
      for (int j = 0; j < NK; j++) win_r[j] <= 32'h0000_0000;
    end else begin
      state_r     <= next_state_s;
      key_ready_r <= (next_state_s != ST_EXPAND);
      rk_ready_r  <= (next_state_s == ST_DONE);
      busy_r      <= (next_state_s == ST_EXPAND);
      if (accept_s) begin
        cnt_r   <= 6'(NK);
        phase_r <= 3'd0;
        rc_r    <= 4'd1;
        for (int j = 0; j < NK; j++) win_r[j] <= keyIn[KEY_BITS-1-32*j -: 32];
      end else if (state_r == ST_EXPAND) begin
        // Counter parks on the last word index rather than running past the buffer.
        if (!last_word_s) cnt_r <= cnt_r + 6'd1;
        if (phase_r == 3'(NK - 1)) begin
          phase_r <= 3'd0;
          rc_r    <= rc_r + 4'd1;
        end else begin
          phase_r <= phase_r + 3'd1;
        end
        for (int j = 0; j < NK - 1; j++) win_r[j] <= win_r[j+1];
        win_r[NK-1] <= new_word_s;
      end
    end
  end

  // Round-key word storage; contents persist across reset.
  always_ff @(posedge clock) begin
    if (accept_s) begin
      for (int j = 0; j < NK; j++) wbuf_r[j] <= keyIn[KEY_BITS-1-32*j -: 32];
    end else if (state_r == ST_EXPAND) begin
      wbuf_r[cnt_r] <= new_word_s;
    end
  end

  assign rd_idx_s  = (rkIndex <= 4'(NR)) ? rkIndex : 4'd0;
  assign rd_base_s = {rd_idx_s, 2'b00};

  // Registered round-key read port, zero unless the schedule is complete.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rk_data_r <= 128'h0;
    end else if (rk_ready_r && (rkIndex <= 4'(NR))) begin
      rk_data_r <= {wbuf_r[rd_base_s], wbuf_r[rd_base_s + 6'd1],
                    wbuf_r[rd_base_s + 6'd2], wbuf_r[rd_base_s + 6'd3]};
    end else begin
      rk_data_r <= 128'h0;
    end
  end

  assign keyReady = key_ready_r;
  assign rkReady  = rk_ready_r;
  assign busy     = busy_r;
  assign rkData   = rk_data_r;

endmodule

// File: doc/key_schedule_engine.md
Name: key_schedule_engine

Overview:
- Sequential AES key-schedule generator. Replaces the per-round combinational expansion with one central block that expands a 128/192/256-bit cipher key one 32-bit word per cycle into a round-key buffer.
- Round keys are served to the cipher rounds through a registered indexed read port.
- This removes the round/iteration mismatch for 192- and 256-bit keys: round keys are always 4-word groups of the flat word array.

Parameters:
- KEY_BITS, 128, cipher key size; legal values 128, 192, 256 (elaboration error otherwise).
- NK, KEY_BITS/32, key words (derived, not overridable).
- NR, NK+6, number of rounds (derived).
- NW, 4*(NR+1), total schedule words: 44/52/60 (derived).

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- keyValid  in  1  new key offered.
- keyReady  out  1  engine can accept a key (IDLE or DONE).
- keyIn  in  KEY_BITS  cipher key; first key byte in MSBs.
- rkIndex  in  4  round-key index, 0..NR.
- rkData  out  128  round key rkIndex, registered.
- rkReady  out  1  full schedule valid for the last accepted key.
- busy  out  1  expansion in progress.

Behaviour:
- Reset values: state=IDLE, keyReady=1, rkReady=0, busy=0, rkData=0, word counter=0. The word buffer is not cleared.
- States: IDLE, EXPAND, DONE.
- Accept occurs when keyValid && keyReady at a rising edge (from IDLE or DONE):
  - w[0..NK-1] is written from keyIn; w[0]=keyIn[KEY_BITS-1 -: 32].
  - Counter i=NK; rkReady=0, busy=1, keyReady=0; next state EXPAND.
- EXPAND writes one word per edge:
  - temp=w[i-1].
  - If i%NK==0: temp=SubWord(RotWord(temp))^{RCON[i/NK],24'h0}.
  - Else if NK==8 and i%8==4: temp=SubWord(temp).
  - w[i]=w[i-NK]^temp, then i++.
- The last NK words are held in a sliding shift window, so no wide buffer read is needed during expansion.
- On the edge that writes w[NW-1]: state=DONE, busy=0, rkReady=1, keyReady=1.
- Latency from the accept edge to rkReady high: NW-NK edges, i.e. 40/46/52.
- keyValid while busy is ignored: no abort, no queuing, and the key is not held.
- Key accepted in DONE: rkReady drops on that edge and expansion restarts. The old round keys are no longer valid.
- Read port:
  - rkData <= {w[4r],w[4r+1],w[4r+2],w[4r+3]} on every edge, where r=rkIndex and w[4r] sits in bits 127:96.
  - rkIndex>NR returns 128'h0.
  - While rkReady=0, rkData is forced to 0.
  - Read latency is 1 cycle, and a read in the same edge that rkReady rises returns 0.
- RCON index max: 10 (128-bit), 8 (192-bit), 7 (256-bit); RCON[1..10]=01,02,04,08,10,20,40,80,1b,36.
- reset_n assertion mid-EXPAND returns immediately to the reset values; no partial schedule is ever flagged ready.
- Counter width is 6 bits; i never exceeds NW-1.

Decomposition:
- Shared package (AESDefinitions): byte_t, keyWord_t (32b), roundKey_t (128b), sbox table, RCON table, KEY_BITS-derived NK/NR/NW constants.
- Sub-module key_schedule_word: combinational single-word step.
  - Inputs: prevWord, wordNkBack, i%NK class, rcon byte.
  - Output: new word.
  - Implements SubWord (4 sbox lookups) and RotWord.
- The top level holds the FSM, counter, window, buffer and read register.

Test Plan:
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c accepted at edge 0:
  - rkReady rises at edge 40.
  - rkIndex=0 returns the key.
  - rkIndex=1 word0=a0fafe17.
  - rkIndex=10 returns d014f9a8c9ee2589e13f0cc8b6630ca6.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - rkReady at edge 46.
  - w[6]=fe0c91f7.
  - rkIndex=12 word3 (w[51])=01002202.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - rkReady at edge 52.
  - w[8]=9ba35411.
  - w[12]=a8b09c1a (SubWord-only branch).
  - w[59]=706c631e.
- Handshake:
  - keyValid pulsed with a different key at edge 10 of an expansion is ignored, and the final schedule matches the first key.
  - New key in DONE drops rkReady next edge and the schedule completes for the new key.
- Reads:
  - rkIndex=15 with rkReady=1 returns 0.
  - Any rkIndex while busy returns 0.
- Reset:
  - reset_n low at edge 20 of an expansion forces rkReady=0, keyReady=1 and rkData=0 asynchronously.
  - A fresh key after release yields the correct schedule.
